led_pwm_fader: RTL
==================

# led_pwm_fader

Downstream stage for the 8-bit demo counter: consumes the counter's 8-bit output and drives the 8 daughterboard LEDs through per-LED PWM with an afterglow fade. A set bit lights its LED at full brightness. A cleared bit's LED dims one level per fade tick until dark. A one-cycle frame pulse per PWM period is exported so the counter can be clock-enabled at a visible rate.

## Interface
- PRESCALE, 4: clk cycles per PWM step; ≥1.
- FADE_PERIODS, 2: PWM periods per fade tick; ≥1.
- clk  input  1  system clock.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- value  input  8  counter value; bit i controls LED i.
- led  output  8  PWM LED drive, 1 = on.
- frame  output  1  one-cycle pulse at end of each PWM period.

## Operation
- pre_cnt (clog2(PRESCALE) bits) counts 0..PRESCALE-1 and wraps. step = (pre_cnt == PRESCALE-1).
- pwm_cnt (4 bits) increments on step and wraps 15→0. period_end = step && pwm_cnt == 15.
- fade_cnt counts period_end events 0..FADE_PERIODS-1 and wraps. fade_tick = period_end && fade_cnt == FADE_PERIODS-1.
- value_q: value registered every clk; single input stage.
- level[i] (4 bits) updates every clk:
  - if value_q[i] = 1: level = 15.
  - else if fade_tick and level ≠ 0: level − 1.
  - otherwise hold.
  - Set has priority over a simultaneous fade tick. Level saturates at 0 and does not wrap.
- duty[i] = level[i] (see Configuration).
- led[i] is registered: led[i] <= (duty[i] == 15) | (pwm_cnt < duty[i]).
  - duty 15 is solid on.
  - duty d < 15 is on for d of 16 steps, i.e. d·PRESCALE clk per period.
  - duty 0 is off.
- frame is registered: frame <= period_end.

## Timing
- Reset, asynchronous, immediate: pre_cnt, pwm_cnt, fade_cnt, value_q, all level, led and frame go to 0.
- First cycle after reset release: pre_cnt = 0, pwm_cnt = 0.
- Rst asserted mid-fade loses all levels; no state survives.
- Latency: value bit sampled at edge k.
  - value_q updates at edge k.
  - level updates at edge k+1.
  - led reflects it at edge k+2.
- PWM period = 16·PRESCALE clk. With defaults: 64 clk.
- frame: high for exactly one clk, once per period, starting one clk after the cycle with pwm_cnt == 15 and pre_cnt == PRESCALE-1.
- Fade tick every 16·PRESCALE·FADE_PERIODS clk (default 128). Full decay 15→0 takes 15 ticks.
- The first fade tick after reset occurs at the end of period FADE_PERIODS.
- Duty changes mid-period take effect on the next clk. No period-boundary latching.
- PRESCALE = 1: step is always 1, and pwm_cnt advances every clk.

## Configuration
- LED_FADE_GAMMA_EN: when defined, duty[i] = G(level[i]).
  - G(0..15) = 0,0,0,1,1,1,2,2,3,4,5,6,8,10,12,15.
  - G is combinational and inserted between level and the led compare register. Latency is unchanged.
- When undefined, duty[i] = level[i] (linear). No table logic is synthesized.

## Test plan
- Reset mid-operation: run 200 clk with value = 8'hFF, then pulse rst high for 3 ns between edges.
  - led and frame must be 0 immediately.
  - After release, first frame appears 64 clk later.
  - No LED lights until value is reasserted.
- Steady set: value = 8'h01 held.
  - led[0] = 1 from the second edge after sampling and stays 1 on every cycle.
  - led[7:1] = 0 throughout.
- Decay, linear build: value 8'h01 for 10 clk, then 8'h00.
  - led[0] stays solid until the first fade tick.
  - Level then goes 15→14: led[0] high 56 of 64 clk per period.
  - After 15 fade ticks led[0] = 0 permanently; level must not wrap to 15.
- Set/fade collision: drive value_q[3] = 1 on the same cycle as a fade_tick while level[3] = 5.
  - level[3] becomes 15, not 4.
  - led[3] is solid on from two edges later.
- Frame cadence: count frame pulses over 640 clk from reset release.
  - Exactly 10 pulses, each 1 clk wide, spaced 64 clk apart.
- Gamma build (LED_FADE_GAMMA_EN defined): hold level[2] at 8 by releasing bit 2 and waiting 7 fade ticks.
  - led[2] high 12 of 64 clk per period (duty 3).
  - Without the macro, same stimulus gives 32 of 64.

Source files
------------

// File: rtl/led_pwm_fader.sv
// led_pwm_fader: per-LED PWM drive with an afterglow fade for the 8-bit demo counter.
// Define LED_FADE_GAMMA_EN to map fade level to duty through a perceptual gamma table.
`timescale 1ns/1ps
module led_pwm_fader #(
    parameter int PRESCALE     = 4,
    parameter int FADE_PERIODS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    output logic [7:0] led,
    output logic       frame
);
    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FADE_W = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(PRESCALE - 1);
    localparam logic [FADE_W-1:0] FADE_MAX = FADE_W'(FADE_PERIODS - 1);

    logic [PRE_W-1:0]  pre_cnt;
    logic [3:0]        pwm_cnt;
    logic [FADE_W-1:0] fade_cnt;
    logic              step;
    logic              period_end;
    logic              fade_tick;
    logic [7:0]        value_p0;
    logic [3:0]        level_p1 [8];
    logic [3:0]        duty [8];

    // Saturating one-level decay: never wraps below dark.
    function automatic logic [3:0] fade_step(input logic [3:0] lvl);
        return (lvl == 4'd0) ? 4'd0 : lvl - 4'd1;
    endfunction

`ifdef LED_FADE_GAMMA_EN
    function automatic logic [3:0] gamma(input logic [3:0] lvl);
        logic [3:0] g;
        case (lvl)
            4'd0, 4'd1, 4'd2: g = 4'd0;
            4'd3, 4'd4, 4'd5: g = 4'd1;
            4'd6, 4'd7:       g = 4'd2;
            4'd8:             g = 4'd3;
            4'd9:             g = 4'd4;
            4'd10:            g = 4'd5;
            4'd11:            g = 4'd6;
            4'd12:            g = 4'd8;
            4'd13:            g = 4'd10;
            4'd14:            g = 4'd12;
            default:          g = 4'd15;
        endcase
        return g;
    endfunction
`endif

    assign step       = (pre_cnt == PRE_MAX);
    assign period_end = step && (pwm_cnt == 4'd15);
    assign fade_tick  = period_end && (fade_cnt == FADE_MAX);

    // Timebase: prescaler -> PWM step counter -> fade period counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt  <= '0;
            pwm_cnt  <= '0;
            fade_cnt <= '0;
        end else begin
            pre_cnt <= step ? '0 : pre_cnt + 1'b1;
            if (step)
                pwm_cnt <= pwm_cnt + 4'd1;
            if (period_end)
                fade_cnt <= (fade_cnt == FADE_MAX) ? '0 : fade_cnt + 1'b1;
        end
    end

    // Stage p0: input register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            value_p0 <= '0;
        else
            value_p0 <= value;
    end

    // Stage p1: per-LED brightness level, set beats a coincident fade tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++)
                level_p1[i] <= 4'd0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (value_p0[i])
                    level_p1[i] <= 4'd15;
                else if (fade_tick)
                    level_p1[i] <= fade_step(level_p1[i]);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
`ifdef LED_FADE_GAMMA_EN
            duty[i] = gamma(level_p1[i]);
`else
            duty[i] = level_p1[i];
`endif
        end
    end

    // Stage p2: PWM compare and frame strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led   <= '0;
            frame <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++)
                led[i] <= (duty[i] == 4'd15) || (pwm_cnt < duty[i]);
            frame <= period_end;
        end
    end

endmodule
